// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic en_pc;
      logic en_if_id;
      logic en_id_ex;
      logic en_ex_mem;
      logic en_mem_wb;
      logic flush_if_id;
      logic flush_id_ex;
      logic flush_ex_mem;
      logic pc_sel_branch;
   } pipe_ctrl_t;

   // All control bits low: full freeze, also the value forced during reset.
   localparam pipe_ctrl_t BUBBLE_CTRL = '0;
   localparam pipe_ctrl_t RUN_CTRL    = '{en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1,
                                          en_ex_mem: 1'b1, en_mem_wb: 1'b1,
                                          flush_if_id: 1'b0, flush_id_ex: 1'b0,
                                          flush_ex_mem: 1'b0, pc_sel_branch: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that overrides the increment.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: memory freeze, taken-branch flush and load-use stall control
// with a data-memory watchdog and stall/flush performance counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 idex_memread,
   input  logic [REG_IDX_W-1:0] idex_rd,
   input  logic                 exmem_membranch,
   input  logic                 exmem_zero,
   input  logic                 exmem_memread,
   input  logic                 exmem_memwrite,
   input  logic                 dmem_ack,
   input  logic                 clr_cnt,
   output logic                 dmem_req,
   output logic                 en_pc,
   output logic                 en_if_id,
   output logic                 en_id_ex,
   output logic                 en_ex_mem,
   output logic                 en_mem_wb,
   output logic                 flush_if_id,
   output logic                 flush_id_ex,
   output logic                 flush_ex_mem,
   output logic                 pc_sel_branch,
   output logic                 mem_err,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_err_q, mem_err_d;
   logic              mem_acc, br_taken, ld_use, timeout, frozen, req;
   pipe_ctrl_t        ctrl;

   assign mem_acc  = exmem_memread | exmem_memwrite;
   assign br_taken = exmem_membranch & exmem_zero;
   assign ld_use   = idex_memread && (idex_rd != '0) &&
                     ((idex_rd == id_rs1) || (idex_rd == id_rs2));
   assign timeout  = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));

   // Next state, watchdog and memory handshake.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      req       = 1'b0;
      frozen    = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_acc) begin
               req = 1'b1;
               if (!dmem_ack) begin
                  frozen  = 1'b1;
                  state_d = MEM_WAIT;
                  wait_d  = WAIT_W'(1);
               end
            end
         end
         MEM_WAIT: begin
            req = 1'b1;
            if (dmem_ack || timeout) begin
               mem_err_d = mem_err_q | ~dmem_ack;
               state_d   = RUN;
               wait_d    = '0;
            end else begin
               frozen = 1'b1;
               if (wait_q != '1) begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Mealy pipeline controls; a branch in EX/MEM masks any load-use hazard.
   always_comb begin
      ctrl = RUN_CTRL;
      if (frozen) begin
         ctrl = BUBBLE_CTRL;
      end else if (br_taken) begin
         ctrl.pc_sel_branch = 1'b1;
         ctrl.flush_if_id   = 1'b1;
         ctrl.flush_id_ex   = 1'b1;
         ctrl.flush_ex_mem  = 1'b1;
      end else if (ld_use) begin
         ctrl.en_pc       = 1'b0;
         ctrl.en_if_id    = 1'b0;
         ctrl.flush_id_ex = 1'b1;
      end
      if (!arst_n) begin
         ctrl = BUBBLE_CTRL;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .inc_i  (arst_n & ~ctrl.en_pc),
      .clr_i  (clr_cnt),
      .cnt_o  (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .inc_i  (ctrl.pc_sel_branch),
      .clr_i  (clr_cnt),
      .cnt_o  (flush_cnt)
   );

   assign dmem_req      = req & arst_n;
   assign en_pc         = ctrl.en_pc;
   assign en_if_id      = ctrl.en_if_id;
   assign en_id_ex      = ctrl.en_id_ex;
   assign en_ex_mem     = ctrl.en_ex_mem;
   assign en_mem_wb     = ctrl.en_mem_wb;
   assign flush_if_id   = ctrl.flush_if_id;
   assign flush_id_ex   = ctrl.flush_id_ex;
   assign flush_ex_mem  = ctrl.flush_ex_mem;
   assign pc_sel_branch = ctrl.pc_sel_branch;
   assign mem_err       = mem_err_q;

endmodule
